mux3_1_arbitro: RTL and testbench
=================================

Name: mux3_1_arbitro

Overview:
- Round-robin arbiter that shares the 32-bit 3:1 data mux among three requesters (A, B, C).
- Drives the mux select pair (controle1, controle2) and registers the selected word into a one-entry output buffer with a valid/ready handshake toward the consumer.
- Bounded bursts stop one source from holding the shared path indefinitely.
- Sits in front of the shared datapath mux in the processor datapath.

Parameters:
- LARGURA, 32, data width of each input and of saida.
- MAX_RAJADA, 4, maximum transfers per grant before forced release (range 1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_a / req_b / req_c  input  1 each  request from source A/B/C; held high while data is offered.
- dado_a / dado_b / dado_c  input  LARGURA each  data offered by source A/B/C.
- ack_a / ack_b / ack_c  output  1 each  transfer accepted from that source this cycle (combinational).
- controle1  output  1  mux select MSB (registered).
- controle2  output  1  mux select LSB (registered).
- saida  output  LARGURA  buffered output word (registered).
- saida_valida  output  1  saida holds an unconsumed word.
- saida_pronta  input  1  consumer accepts saida this cycle.

Behaviour:
- Select encoding {controle1,controle2}:
  - 00 = A, 01 = B, 10 = C.
  - 11 is never produced.
- Reset (reset=0, asynchronous):
  - estado=OCIOSO, controle1=0, controle2=0, saida=0, saida_valida=0.
  - Burst counter=0; last-granted pointer=C, so A has first priority.
  - ack_* = 0 while reset is low.
- States: OCIOSO, CONCEDIDO.
- OCIOSO:
  - If any req_x is high at a rising edge, grant the first requester in rotating order after the last-granted source.
  - Load controle1/controle2 and clear the counter, then go to CONCEDIDO.
  - With no requests, stay in OCIOSO; select bits hold their old value.
- Grant latency: request sampled at edge N; first possible ack is in cycle N+1.
- espaco = !saida_valida || saida_pronta.
- ack_x = (estado==CONCEDIDO) && (x is granted) && req_x && espaco.
  - At most one ack is high per cycle.
  - ack_x is never high for a non-granted source.
- On ack at an edge:
  - saida <= dado of the granted source; saida_valida <= 1; counter += 1.
- Buffer behaviour:
  - saida_pronta with no ack: saida_valida <= 0; saida keeps its last value.
  - Simultaneous pop and ack: saida is replaced and saida_valida stays 1 (full throughput, one word per cycle).
  - While saida_valida=1 and saida_pronta=0, saida and saida_valida hold stable (backpressure); no ack is issued.
- Release from CONCEDIDO (go to OCIOSO; pointer <= granted source) when either:
  - the counter reaches MAX_RAJADA on this edge's ack, or
  - req of the granted source is low at an edge.
- Release costs exactly one OCIOSO cycle (a bubble) before the next grant.
- Requests from non-granted sources during CONCEDIDO are ignored until the next OCIOSO.
- After release, the pointer guarantees the same source has lowest priority in the next arbitration.
- The output buffer is not flushed on release; a pending word stays valid until it is popped.
- Reset asserted mid-burst or with saida_valida=1: the pending word is discarded and all outputs return to reset values asynchronously.

Test Plan:
- Reset then idle → all outputs 0, select 00, no ack for 5 cycles.
- Single source:
  - Stimulus: req_b=1 with dado_b=10, saida_pronta=1.
  - Required: select 01 one cycle after the request; ack_b every cycle; saida=10, saida_valida=1.
  - Required: after 4 acks, one OCIOSO bubble, then B is re-granted.
- Fairness:
  - Stimulus: req_a=req_b=req_c=1 (dados 8, 10, 11), pronta=1.
  - Required: grant order A, B, C, A…; each grant gives exactly 4 saida words (8×4, 10×4, 11×4), each followed by one bubble.
- Backpressure:
  - Stimulus: granted C with dado_c=15, saida_pronta=0.
  - Required: one ack; saida=15 and valida=1 held stable; no further ack_c until pronta=1; counter does not advance.
- Early drop:
  - Stimulus: A granted, req_a falls after 2 transfers, req_c=1 (dado_c=40).
  - Required: release after the 2nd transfer; C granted with select 10; saida=40.
- Reset mid-burst:
  - Stimulus: assert reset low asynchronously (not on a clock edge) with saida_valida=1.
  - Required: saida=0, valida=0, select 00, acks 0 immediately; after reset release, arbitration restarts with A first.

Source files
------------

// File: rtl/mux3_1_arbitro.sv
// mux3_1_arbitro
// Round-robin arbiter in front of the shared 32-bit 3:1 datapath mux.
// Grants one of three requesters (A, B, C), drives the mux select pair,
// and captures the selected word into a one-entry valid/ready buffer.
// A grant ends after MAX_RAJADA transfers or when the granted source
// drops its request; each release costs one idle cycle before re-arbitration.
module mux3_1_arbitro #(
    parameter int LARGURA    = 32,
    parameter int MAX_RAJADA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_a,
    input  logic               req_b,
    input  logic               req_c,
    input  logic [LARGURA-1:0] dado_a,
    input  logic [LARGURA-1:0] dado_b,
    input  logic [LARGURA-1:0] dado_c,
    output logic               ack_a,
    output logic               ack_b,
    output logic               ack_c,
    output logic               controle1,
    output logic               controle2,
    output logic [LARGURA-1:0] saida,
    output logic               saida_valida,
    input  logic               saida_pronta
);

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    // Source encoding doubles as the mux select {controle1, controle2}.
    typedef enum logic [1:0] {
        FONTE_A = 2'b00,
        FONTE_B = 2'b01,
        FONTE_C = 2'b10
    } fonte_t;

    localparam logic [3:0] C_MAX = 4'(MAX_RAJADA);

    estado_t            r_estado;
    estado_t            w_estado_prox;
    fonte_t             r_sel;
    fonte_t             w_sel_prox;
    fonte_t             r_ultimo;
    fonte_t             w_ultimo_prox;
    fonte_t             w_vencedora;
    logic [3:0]         r_cont;
    logic [3:0]         w_cont_prox;
    logic [3:0]         w_cont_inc;
    logic [LARGURA-1:0] r_saida;
    logic               r_valida;

    logic               w_tem_req;
    logic               w_req_conc;
    logic [LARGURA-1:0] w_dado_conc;
    logic               w_espaco;
    logic               w_ack;
    logic               w_fim_rajada;

    assign w_tem_req  = req_a | req_b | req_c;
    assign w_espaco   = ~r_valida | saida_pronta;
    assign w_cont_inc = r_cont + 4'd1;

    // Request and data of the currently granted source (the shared 3:1 mux).
    always_comb begin
        w_req_conc  = 1'b0;
        w_dado_conc = '0;
        case (r_sel)
            FONTE_A: begin
                w_req_conc  = req_a;
                w_dado_conc = dado_a;
            end
            FONTE_B: begin
                w_req_conc  = req_b;
                w_dado_conc = dado_b;
            end
            FONTE_C: begin
                w_req_conc  = req_c;
                w_dado_conc = dado_c;
            end
            default: begin
                w_req_conc  = 1'b0;
                w_dado_conc = '0;
            end
        endcase
    end

    // Rotating priority: search starts at the source after the last one granted.
    always_comb begin
        w_vencedora = FONTE_A;
        case (r_ultimo)
            FONTE_A: begin
                if (req_b)      w_vencedora = FONTE_B;
                else if (req_c) w_vencedora = FONTE_C;
                else            w_vencedora = FONTE_A;
            end
            FONTE_B: begin
                if (req_c)      w_vencedora = FONTE_C;
                else if (req_a) w_vencedora = FONTE_A;
                else            w_vencedora = FONTE_B;
            end
            default: begin
                if (req_a)      w_vencedora = FONTE_A;
                else if (req_b) w_vencedora = FONTE_B;
                else            w_vencedora = FONTE_C;
            end
        endcase
    end

    assign w_ack        = (r_estado == CONCEDIDO) & w_req_conc & w_espaco;
    assign w_fim_rajada = w_ack & (w_cont_inc == C_MAX);

    // Next-state, select, burst counter and last-granted pointer.
    always_comb begin
        w_estado_prox = r_estado;
        w_sel_prox    = r_sel;
        w_ultimo_prox = r_ultimo;
        w_cont_prox   = r_cont;
        case (r_estado)
            OCIOSO: begin
                if (w_tem_req) begin
                    w_sel_prox    = w_vencedora;
                    w_cont_prox   = '0;
                    w_estado_prox = CONCEDIDO;
                end
            end
            CONCEDIDO: begin
                if (w_ack) begin
                    w_cont_prox = w_cont_inc;
                end
                // A dropped request releases even without a transfer;
                // the buffer is deliberately left untouched on release.
                if (!w_req_conc || w_fim_rajada) begin
                    w_ultimo_prox = r_sel;
                    w_estado_prox = OCIOSO;
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_sel    <= FONTE_A;
            r_ultimo <= FONTE_C;
            r_cont   <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_sel    <= w_sel_prox;
            r_ultimo <= w_ultimo_prox;
            r_cont   <= w_cont_prox;
        end
    end

    // One-entry output buffer: load on ack, empty on pop without a new ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_saida  <= '0;
            r_valida <= 1'b0;
        end else if (w_ack) begin
            r_saida  <= w_dado_conc;
            r_valida <= 1'b1;
        end else if (saida_pronta) begin
            r_valida <= 1'b0;
        end
    end

    assign ack_a        = w_ack & (r_sel == FONTE_A);
    assign ack_b        = w_ack & (r_sel == FONTE_B);
    assign ack_c        = w_ack & (r_sel == FONTE_C);
    assign controle1    = r_sel[1];
    assign controle2    = r_sel[0];
    assign saida        = r_saida;
    assign saida_valida = r_valida;

endmodule

// File: tb/tb_mux3_1_arbitro.sv
// tb_mux3_1_arbitro
// Scenario tasks plus a randomized run, checked against a source-level
// model of the round-robin arbiter and its one-entry output buffer.
module tb_mux3_1_arbitro;

    localparam int LARGURA = 32;
    localparam int MAX     = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [LARGURA-1:0] dado_a = '0, dado_b = '0, dado_c = '0;
    logic               saida_pronta = 1'b0;
    logic               ack_a, ack_b, ack_c;
    logic               controle1, controle2;
    logic [LARGURA-1:0] saida;
    logic               saida_valida;

    int checks   = 0;
    int failures = 0;

    // Model: granted source (-1 when idle), last-granted pointer, transfers
    // in this grant, select value, buffered word and its valid flag.
    int                 m_conc  = -1;
    int                 m_ptr   = 2;
    int                 m_cont  = 0;
    int                 m_sel   = 0;
    logic [LARGURA-1:0] m_saida = '0;
    bit                 m_valid = 1'b0;

    mux3_1_arbitro #(.LARGURA(LARGURA), .MAX_RAJADA(MAX)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .dado_a(dado_a), .dado_b(dado_b), .dado_c(dado_c),
        .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c),
        .controle1(controle1), .controle2(controle2),
        .saida(saida), .saida_valida(saida_valida),
        .saida_pronta(saida_pronta)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic bit req_of(int s);
        case (s)
            0: return req_a;
            1: return req_b;
            default: return req_c;
        endcase
    endfunction

    function automatic logic [LARGURA-1:0] dado_of(int s);
        case (s)
            0: return dado_a;
            1: return dado_b;
            default: return dado_c;
        endcase
    endfunction

    function automatic int m_ack_src();
        if (m_conc >= 0 && req_of(m_conc) && (!m_valid || saida_pronta))
            return m_conc;
        return -1;
    endfunction

    // Expected {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}.
    function automatic logic [5:0] m_ctl();
        logic [5:0] e;
        int a;
        a = m_ack_src();
        e = '0;
        if (a >= 0) e[5-a] = 1'b1;
        e[2:1] = m_sel[1:0];
        e[0]   = m_valid;
        return e;
    endfunction

    task automatic model_reset();
        m_conc  = -1;
        m_ptr   = 2;
        m_cont  = 0;
        m_sel   = 0;
        m_saida = '0;
        m_valid = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int a;
        int s;
        a = m_ack_src();
        if (m_conc < 0) begin
            for (int i = 1; i <= 3; i++) begin
                s = (m_ptr + i) % 3;
                if (req_of(s)) begin
                    m_conc = s;
                    m_sel  = s;
                    m_cont = 0;
                    break;
                end
            end
        end else begin
            if (a >= 0) m_cont++;
            if (!req_of(m_conc) || m_cont == MAX) begin
                m_ptr  = m_conc;
                m_conc = -1;
            end
        end
        if (a >= 0) begin
            m_saida = dado_of(a);
            m_valid = 1'b1;
        end else if (saida_pronta) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        req_a = 0; req_b = 0; req_c = 0; saida_pronta = 0;
        reset = 1'b0;
        #2;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req_a = 1; req_b = 1; req_c = 1; saida_pronta = 1;
        dado_a = 32'h11; dado_b = 32'h22; dado_c = 32'h33;
        #3;
        checks++;
        if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== 6'b0 || saida !== '0) begin
            failures++;
            $display("FAIL reset_async ctl=%b saida=%0h exp ctl=000000 saida=0",
                     {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, saida);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== 6'b0 || saida !== '0) begin
            failures++;
            $display("FAIL reset_held ctl=%b saida=%0h exp ctl=000000 saida=0",
                     {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, saida);
        end
        req_a = 0; req_b = 0; req_c = 0; saida_pronta = 0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL idle_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL idle_saida cyc=%0d got=%0h exp=%0h", c, saida, m_saida);
            end
            model_edge();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_single_source();
        logic [11:0] pat;
        do_reset();
        dado_b = 32'd10; req_b = 1; saida_pronta = 1;
        pat = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL single_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL single_saida cyc=%0d got=%0d exp=%0d", c, saida, m_saida);
            end
            if (c == 1) begin
                checks++;
                if ({controle1, controle2} !== 2'b01) begin
                    failures++;
                    $display("FAIL single_select got=%b exp=01", {controle1, controle2});
                end
            end
            pat[11-c] = ack_b;
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (pat !== 12'b011110111101) begin
            failures++;
            $display("FAIL single_ack_pattern got=%b exp=011110111101", pat);
        end
        checks++;
        if (saida !== 32'd10 || saida_valida !== 1'b1) begin
            failures++;
            $display("FAIL single_final saida=%0d valida=%b exp 10/1", saida, saida_valida);
        end
    endtask

    task automatic test_fairness();
        int                 order[$];
        logic [LARGURA-1:0] words[$];
        bit                 acked;
        int                 es;
        logic [LARGURA-1:0] ew;
        do_reset();
        dado_a = 32'd8; dado_b = 32'd10; dado_c = 32'd11;
        req_a = 1; req_b = 1; req_c = 1; saida_pronta = 1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL fair_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL fair_saida cyc=%0d got=%0d exp=%0d", c, saida, m_saida);
            end
            acked = ack_a | ack_b | ack_c;
            if (ack_a) order.push_back(0);
            if (ack_b) order.push_back(1);
            if (ack_c) order.push_back(2);
            model_edge();
            @(posedge clock);
            #1;
            if (acked) words.push_back(saida);
        end
        checks++;
        if (order.size() < 13 || words.size() < 13) begin
            failures++;
            $display("FAIL fair_count got=%0d exp>=13", order.size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                es = (i / 4) % 3;
                ew = (es == 0) ? 32'd8 : (es == 1) ? 32'd10 : 32'd11;
                checks++;
                if (order[i] != es || words[i] !== ew) begin
                    failures++;
                    $display("FAIL fair_order idx=%0d src=%0d word=%0d exp src=%0d word=%0d",
                             i, order[i], words[i], es, ew);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         nack;
        logic [5:0] pat;
        do_reset();
        dado_c = 32'd15; req_c = 1; saida_pronta = 0;
        nack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL bp_saida cyc=%0d got=%0d exp=%0d", c, saida, m_saida);
            end
            if (ack_c) nack++;
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (nack != 1 || saida !== 32'd15 || saida_valida !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall acks=%0d saida=%0d valida=%b exp 1/15/1", nack, saida, saida_valida);
        end
        saida_pronta = 1;
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL bp_resume_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            pat[5-c] = ack_c;
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (pat !== 6'b111011) begin
            failures++;
            $display("FAIL bp_resume_pattern got=%b exp=111011", pat);
        end
    endtask

    task automatic test_early_drop();
        int na;
        bit seen_c;
        do_reset();
        dado_a = 32'd7; dado_c = 32'd40;
        req_a = 1; req_c = 1; saida_pronta = 1;
        na = 0;
        seen_c = 0;
        for (int c = 0; c < 9; c++) begin
            req_a = (na < 2);
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL drop_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL drop_saida cyc=%0d got=%0d exp=%0d", c, saida, m_saida);
            end
            if (ack_a) na++;
            if (ack_c && {controle1, controle2} == 2'b10) seen_c = 1;
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (na != 2 || !seen_c || saida !== 32'd40) begin
            failures++;
            $display("FAIL drop_result acks_a=%0d c_granted=%0d saida=%0d exp 2/1/40", na, seen_c, saida);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] pat;
        do_reset();
        dado_b = 32'd55; req_b = 1; saida_pronta = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL mid_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (saida_valida !== 1'b1 || {controle1, controle2} !== 2'b01 || saida !== 32'd55) begin
            failures++;
            $display("FAIL mid_pre valida=%b sel=%b saida=%0d exp 1/01/55",
                     saida_valida, {controle1, controle2}, saida);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== 6'b0 || saida !== '0) begin
            failures++;
            $display("FAIL mid_async ctl=%b saida=%0h exp ctl=000000 saida=0",
                     {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, saida);
        end
        model_reset();
        dado_a = 32'd8; dado_c = 32'd11;
        req_a = 1; req_b = 1; req_c = 1;
        reset = 1'b1;
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL mid_restart_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            pat[3-c] = ack_a;
            model_edge();
            @(posedge clock);
            #1;
        end
        checks++;
        if (pat !== 4'b0111) begin
            failures++;
            $display("FAIL mid_restart_a_first got=%b exp=0111", pat);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            if ($urandom_range(0, 3) == 0) req_c = ~req_c;
            dado_a = $urandom;
            dado_b = $urandom;
            dado_c = $urandom;
            saida_pronta = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            checks++;
            if ({ack_a, ack_b, ack_c, controle1, controle2, saida_valida} !== m_ctl()) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c,
                         {ack_a, ack_b, ack_c, controle1, controle2, saida_valida}, m_ctl());
            end
            checks++;
            if (saida !== m_saida) begin
                failures++;
                $display("FAIL rand_saida cyc=%0d got=%0h exp=%0h", c, saida, m_saida);
            end
            model_edge();
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_early_drop();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
